// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS_32 pipeline: load-use stalls,
// data-memory wait freezes with timeout, and branch flushes, plus perf counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_load,
    input  logic [4:0]       id_dest,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             mem_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt, next_wait_cnt;
    logic              ex_valid, ex_is_load;
    logic [4:0]        ex_dest;
    logic              load_use;

    // The instruction now in EX is a load whose result ID needs next cycle.
    assign load_use = ex_valid & ex_is_load & (ex_dest != 5'd0) & id_valid &
                      ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_write    = 1'b1;
        idex_bubble   = 1'b0;
        exmem_write   = 1'b1;
        exmem_flush   = 1'b0;
        mem_timeout   = 1'b0;
        next_state    = state;
        next_wait_cnt = wait_cnt;

        if (rst) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_write    = 1'b0;
            exmem_write   = 1'b0;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            exmem_flush   = 1'b1;
            next_state    = S_RUN;
            next_wait_cnt = '0;
        end else if (mem_branch_taken) begin
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            exmem_flush   = 1'b1;
            next_state    = S_RUN;
            next_wait_cnt = '0;
        end else if (state == S_WAIT) begin
            // Release cycles fall through to the normal all-write outputs.
            if (dmem_ready) begin
                next_state = S_RUN;
            end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                mem_timeout = 1'b1;
                next_state  = S_RUN;
            end else begin
                pc_write      = 1'b0;
                ifid_write    = 1'b0;
                idex_write    = 1'b0;
                exmem_write   = 1'b0;
                next_wait_cnt = wait_cnt + WAIT_W'(1);
            end
        end else if (mem_access && !dmem_ready) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_write    = 1'b0;
            exmem_write   = 1'b0;
            next_state    = S_WAIT;
            next_wait_cnt = WAIT_W'(1);
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // The EX shadow follows ID/EX exactly: loaded when ID/EX loads, NOP on a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RUN;
            wait_cnt   <= '0;
            ex_valid   <= 1'b0;
            ex_is_load <= 1'b0;
            ex_dest    <= 5'd0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
            if (idex_write) begin
                if (idex_bubble) begin
                    ex_valid   <= 1'b0;
                    ex_is_load <= 1'b0;
                    ex_dest    <= 5'd0;
                end else begin
                    ex_valid   <= id_valid;
                    ex_is_load <= id_is_load;
                    ex_dest    <= id_dest;
                end
            end
            if (!pc_write && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (mem_branch_taken && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
